instseq: RTL and testbench

Instruction register and cycle sequencer for the 6502 core. It latches the opcode from the data bus at the end of each fetch cycle and maintains the 3-bit `cycle` count. It also detects and prioritises reset, NMI and IRQ requests, and injects opcode `8'h00` when an interrupt is taken. Its outputs drive the instruction decoder's `inst`, `cycle`, `clr`, `nmi` and `irq` inputs, and it consumes the decoder's `icyc`, `rcyc`, `scyc` and `sinst` strobes.

---
 rtl/instseq_if.sv | 49 ++++
 rtl/instseq.sv | 183 ++++++++++++++++++
 tb/tb_instseq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/instseq_if.sv
// ---------------------------------------------------------------------------
// instseq_if
// Signal bundle between the instruction sequencer and its neighbours.
//   The slave modport belongs to the sequencer. The master modport belongs to
//   whatever drives the bus, the decoder strobes and the interrupt lines.
//
//   databus       8  opcode byte presented during a fetch cycle
//   icyc          1  decoder strobe: advance cycle
//   rcyc          1  decoder strobe: end of instruction, fetch next
//   scyc          1  decoder strobe: stall
//   sinst         1  decoder strobe: interrupt/reset sequence acknowledge
//   nmi           1  raw NMI request (edge-sensitive)
//   irq           1  raw IRQ request (level-sensitive)
//   irqdis        1  status I flag, masks irq
//   inst          8  current opcode
//   cycle         3  current instruction cycle
//   fetch         1  opcode fetch cycle in progress
//   clrpend       1  reset pending
//   nmipend       1  NMI pending
//   irqpend       1  IRQ pending
//   seqerr        1  sticky cycle-overflow error
// ---------------------------------------------------------------------------
interface instseq_if;
    logic [7:0] databus;
    logic       icyc;
    logic       rcyc;
    logic       scyc;
    logic       sinst;
    logic       nmi;
    logic       irq;
    logic       irqdis;
    logic [7:0] inst;
    logic [2:0] cycle;
    logic       fetch;
    logic       clrpend;
    logic       nmipend;
    logic       irqpend;
    logic       seqerr;

    modport slave (
        input  databus, icyc, rcyc, scyc, sinst, nmi, irq, irqdis,
        output inst, cycle, fetch, clrpend, nmipend, irqpend, seqerr
    );

    modport master (
        output databus, icyc, rcyc, scyc, sinst, nmi, irq, irqdis,
        input  inst, cycle, fetch, clrpend, nmipend, irqpend, seqerr
    );
endinterface

// File: rtl/instseq.sv
// ---------------------------------------------------------------------------
// instseq
// Instruction register and cycle sequencer for the 6502 core.
// It latches the opcode from the data bus at the end of each fetch cycle and
// keeps the 3-bit cycle count. It also tracks pending reset, NMI and IRQ
// requests, and substitutes opcode 00 at a fetch boundary whenever one of
// them is pending.
//
// Ports
//   clk   in   core clock, rising edge
//   clr   in   synchronous active-high reset
//   bus   slave modport of instseq_if (strobes, request lines, outputs)
//
// Configuration
//   INSTSEQ_NMI_EN  when defined, builds the NMI edge detector and gives
//                   nmipend priority between clrpend and irqpend. When it is
//                   undefined, nmipend is constant 0 and nmi is ignored.
// ---------------------------------------------------------------------------
module instseq (
    input  logic       clk,
    input  logic       clr,
    instseq_if.slave   bus
);

    typedef enum logic {
        ST_EXEC  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_inst;
    logic [7:0] w_inst_next;
    logic [2:0] r_cycle;
    logic [2:0] w_cycle_next;
    logic       r_seqerr;
    logic       w_seqerr_next;
    logic       r_clrpend;
    logic       w_clrpend_next;
    logic       r_nmipend;
    logic       w_nmipend_next;
    logic       r_irqpend;
    logic       w_irqpend_next;

    logic       w_nmi_edge;
    logic       w_any_pend;
    logic       w_ack;

    // ------------------------------------------------------------------
    // NMI edge detector
    // ------------------------------------------------------------------
`ifdef INSTSEQ_NMI_EN
    logic r_nmi_dly;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_nmi_dly <= 1'b0;
        end else begin
            r_nmi_dly <= bus.nmi;
        end
    end

    assign w_nmi_edge = bus.nmi & ~r_nmi_dly;
`else
    logic w_unused_nmi;
    assign w_unused_nmi = bus.nmi;
    assign w_nmi_edge   = 1'b0;
`endif

    assign w_any_pend = r_clrpend | r_nmipend | r_irqpend;

    // The acknowledge is only meaningful in the first cycle of the injected
    // BRK-style sequence (opcode 00, cycle 0).
    assign w_ack = bus.sinst && (r_inst == 8'h00) && (r_cycle == 3'd0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= ST_EXEC;
            r_inst    <= 8'h00;
            r_cycle   <= 3'd0;
            r_seqerr  <= 1'b0;
            r_clrpend <= 1'b1;
            r_nmipend <= 1'b0;
            r_irqpend <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_inst    <= w_inst_next;
            r_cycle   <= w_cycle_next;
            r_seqerr  <= w_seqerr_next;
            r_clrpend <= w_clrpend_next;
            r_nmipend <= w_nmipend_next;
            r_irqpend <= w_irqpend_next;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_inst_next   = r_inst;
        w_cycle_next  = r_cycle;
        w_seqerr_next = r_seqerr;

        case (r_state)
            ST_EXEC: begin
                if (bus.scyc) begin
                    // stall: hold everything
                end else if (bus.rcyc) begin
                    w_cycle_next = 3'd0;
                    w_state_next = ST_FETCH;
                end else if (bus.icyc) begin
                    // 3-bit add wraps 7 -> 0 on its own; flag the overflow
                    w_cycle_next = r_cycle + 3'd1;
                    if (r_cycle == 3'd7) begin
                        w_seqerr_next = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (bus.scyc) begin
                    // stall: hold everything
                end else if (bus.rcyc) begin
                    // re-fetch: remain in the fetch cycle
                    w_cycle_next = 3'd0;
                end else begin
                    // fetch always lasts one clock; icyc has no effect here
                    w_state_next = ST_EXEC;
                    if (w_any_pend) begin
                        w_inst_next  = 8'h00;
                        w_cycle_next = 3'd0;
                    end else begin
                        w_inst_next  = bus.databus;
                        w_cycle_next = 3'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_EXEC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pending request flags
    // ------------------------------------------------------------------
    always_comb begin
        w_clrpend_next = r_clrpend;
        w_nmipend_next = r_nmipend | w_nmi_edge;
        w_irqpend_next = bus.irq & ~bus.irqdis;

        // Only the highest-priority pending request is retired. A fresh
        // NMI edge in the same clock as its own ack keeps nmipend set.
        if (w_ack) begin
            if (r_clrpend) begin
                w_clrpend_next = 1'b0;
            end else if (r_nmipend) begin
                w_nmipend_next = w_nmi_edge;
            end else if (r_irqpend) begin
                w_irqpend_next = 1'b0;
            end
        end

`ifndef INSTSEQ_NMI_EN
        w_nmipend_next = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.inst    = r_inst;
    assign bus.cycle   = r_cycle;
    assign bus.fetch   = (r_state == ST_FETCH);
    assign bus.clrpend = r_clrpend;
    assign bus.nmipend = r_nmipend;
    assign bus.irqpend = r_irqpend;
    assign bus.seqerr  = r_seqerr;

endmodule

// File: tb/tb_instseq.sv
// ---------------------------------------------------------------------------
// tb_instseq
// Directed self-checking bench for instseq. Inputs change and outputs are
// checked 1 ns after each rising clock edge. The NMI scenario adapts to
// whether INSTSEQ_NMI_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instseq;

    logic clk;
    logic clr;
    int   total;
    int   bad;

    instseq_if bus ();

    instseq dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; report the resulting state.
    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t clr=%b fetch=%b inst=%h cycle=%0d clrp=%b nmip=%b irqp=%b seqerr=%b",
                 $time, clr, bus.fetch, bus.inst, bus.cycle, bus.clrpend,
                 bus.nmipend, bus.irqpend, bus.seqerr);
    endtask

    task automatic test_reset();
        clr = 1'b1;
        step();
        step();
        total++; if (bus.cycle !== 3'd0) begin bad++; $display("FAIL reset_cycle got=%0d exp=0", bus.cycle); end
        total++; if (bus.inst !== 8'h00) begin bad++; $display("FAIL reset_inst got=%h exp=00", bus.inst); end
        total++; if (bus.clrpend !== 1'b1) begin bad++; $display("FAIL reset_clrpend got=%b exp=1", bus.clrpend); end
        total++; if (bus.fetch !== 1'b0) begin bad++; $display("FAIL reset_fetch got=%b exp=0", bus.fetch); end
        total++; if (bus.nmipend !== 1'b0 || bus.irqpend !== 1'b0 || bus.seqerr !== 1'b0) begin
            bad++; $display("FAIL reset_flags got=%b%b%b exp=000", bus.nmipend, bus.irqpend, bus.seqerr); end
        clr = 1'b0;
        bus.sinst = 1'b1;
        step();
        bus.sinst = 1'b0;
        total++; if (bus.clrpend !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", bus.clrpend); end
    endtask

    task automatic test_fetch();
        bus.rcyc = 1'b1; step();
        bus.rcyc = 1'b0; bus.databus = 8'h69; step();
        bus.icyc = 1'b1; step(); step();
        bus.icyc = 1'b0;
        total++; if (bus.inst !== 8'h69 || bus.cycle !== 3'd3) begin
            bad++; $display("FAIL fetch_setup got=%h/%0d exp=69/3", bus.inst, bus.cycle); end
        bus.rcyc = 1'b1; step();
        total++; if (bus.fetch !== 1'b1 || bus.cycle !== 3'd0 || bus.inst !== 8'h69) begin
            bad++; $display("FAIL fetch_enter got=%b/%0d/%h exp=1/0/69", bus.fetch, bus.cycle, bus.inst); end
        // icyc during a fetch cycle must not matter
        bus.rcyc = 1'b0; bus.databus = 8'h6D; bus.icyc = 1'b1; step();
        bus.icyc = 1'b0;
        total++; if (bus.inst !== 8'h6D || bus.cycle !== 3'd1 || bus.fetch !== 1'b0) begin
            bad++; $display("FAIL fetch_latch got=%h/%0d/%b exp=6d/1/0", bus.inst, bus.cycle, bus.fetch); end
    endtask

    task automatic test_irq_mask();
        bus.irq = 1'b1; bus.irqdis = 1'b0; step();
        total++; if (bus.irqpend !== 1'b1) begin bad++; $display("FAIL irq_pend got=%b exp=1", bus.irqpend); end
        bus.rcyc = 1'b1; step();
        bus.rcyc = 1'b0; bus.databus = 8'h18; step();
        total++; if (bus.inst !== 8'h00 || bus.cycle !== 3'd0) begin
            bad++; $display("FAIL irq_inject got=%h/%0d exp=00/0", bus.inst, bus.cycle); end
        bus.sinst = 1'b1; step();
        bus.sinst = 1'b0; bus.irq = 1'b0;
        total++; if (bus.irqpend !== 1'b0) begin bad++; $display("FAIL irq_ack got=%b exp=0", bus.irqpend); end
        bus.irq = 1'b1; bus.irqdis = 1'b1;
        bus.rcyc = 1'b1; step();
        bus.rcyc = 1'b0; step();
        total++; if (bus.inst !== 8'h18 || bus.cycle !== 3'd1 || bus.irqpend !== 1'b0) begin
            bad++; $display("FAIL irq_masked got=%h/%0d/%b exp=18/1/0", bus.inst, bus.cycle, bus.irqpend); end
        bus.irq = 1'b0; bus.irqdis = 1'b0;
    endtask

    task automatic test_priority();
`ifdef INSTSEQ_NMI_EN
        bus.nmi = 1'b1; bus.irq = 1'b1; step();
        total++; if (bus.nmipend !== 1'b1 || bus.irqpend !== 1'b1) begin
            bad++; $display("FAIL prio_both got=%b%b exp=11", bus.nmipend, bus.irqpend); end
        // ack while inst=18 is ignored
        bus.sinst = 1'b1; step();
        bus.sinst = 1'b0; bus.nmi = 1'b0;
        total++; if (bus.nmipend !== 1'b1 || bus.irqpend !== 1'b1) begin
            bad++; $display("FAIL prio_ign got=%b%b exp=11", bus.nmipend, bus.irqpend); end
        bus.rcyc = 1'b1; step();
        bus.rcyc = 1'b0; bus.databus = 8'hAA; step();
        total++; if (bus.inst !== 8'h00 || bus.cycle !== 3'd0) begin
            bad++; $display("FAIL prio_inject got=%h/%0d exp=00/0", bus.inst, bus.cycle); end
        // new edge coincident with the NMI ack: set wins
        bus.sinst = 1'b1; bus.nmi = 1'b1; step();
        total++; if (bus.nmipend !== 1'b1 || bus.irqpend !== 1'b1) begin
            bad++; $display("FAIL prio_setwins got=%b%b exp=11", bus.nmipend, bus.irqpend); end
        step();
        bus.sinst = 1'b0; bus.nmi = 1'b0;
        total++; if (bus.nmipend !== 1'b0 || bus.irqpend !== 1'b1) begin
            bad++; $display("FAIL prio_nmiack got=%b%b exp=01", bus.nmipend, bus.irqpend); end
`else
        bus.nmi = 1'b1; bus.irq = 1'b1; step();
        total++; if (bus.nmipend !== 1'b0 || bus.irqpend !== 1'b1) begin
            bad++; $display("FAIL prio_nonmi got=%b%b exp=01", bus.nmipend, bus.irqpend); end
        bus.nmi = 1'b0;
`endif
        bus.rcyc = 1'b1; step();
        bus.rcyc = 1'b0; bus.databus = 8'hAA; step();
        total++; if (bus.inst !== 8'h00 || bus.cycle !== 3'd0) begin
            bad++; $display("FAIL prio_irqinj got=%h/%0d exp=00/0", bus.inst, bus.cycle); end
        bus.sinst = 1'b1; step();
        bus.sinst = 1'b0; bus.irq = 1'b0;
        total++; if (bus.irqpend !== 1'b0 || bus.nmipend !== 1'b0) begin
            bad++; $display("FAIL prio_irqack got=%b%b exp=00", bus.nmipend, bus.irqpend); end
    endtask

    task automatic test_stall_overflow();
        bus.icyc = 1'b1; step(); step();
        bus.scyc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus.cycle !== 3'd2) begin bad++; $display("FAIL stall_%0d got=%0d exp=2", i, bus.cycle); end
        end
        bus.scyc = 1'b0;
        for (int i = 0; i < 5; i++) step();
        total++; if (bus.cycle !== 3'd7 || bus.seqerr !== 1'b0) begin
            bad++; $display("FAIL ovf_at7 got=%0d/%b exp=7/0", bus.cycle, bus.seqerr); end
        step();
        total++; if (bus.cycle !== 3'd0 || bus.seqerr !== 1'b1) begin
            bad++; $display("FAIL ovf_wrap got=%0d/%b exp=0/1", bus.cycle, bus.seqerr); end
        bus.icyc = 1'b0; step(); step();
        total++; if (bus.seqerr !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", bus.seqerr); end
    endtask

    task automatic test_abort();
        bus.rcyc = 1'b1; step();
        bus.rcyc = 1'b0; bus.databus = 8'h6D; step();
        bus.icyc = 1'b1; step(); step(); step();
        bus.icyc = 1'b0;
        total++; if (bus.inst !== 8'h6D || bus.cycle !== 3'd4) begin
            bad++; $display("FAIL abort_setup got=%h/%0d exp=6d/4", bus.inst, bus.cycle); end
        clr = 1'b1; step();
        clr = 1'b0;
        total++; if (bus.inst !== 8'h00 || bus.cycle !== 3'd0 || bus.fetch !== 1'b0 || bus.clrpend !== 1'b1 || bus.seqerr !== 1'b0) begin
            bad++; $display("FAIL abort_reset got=%h/%0d/%b/%b/%b exp=00/0/0/1/0",
                            bus.inst, bus.cycle, bus.fetch, bus.clrpend, bus.seqerr); end
    endtask

    task automatic test_back_to_back();
        bus.rcyc = 1'b1; step();
        bus.rcyc = 1'b0; bus.scyc = 1'b1; bus.databus = 8'hA9; step();
        total++; if (bus.fetch !== 1'b1) begin bad++; $display("FAIL b2b_stall got=%b exp=1", bus.fetch); end
        bus.scyc = 1'b0; bus.rcyc = 1'b1; step();
        total++; if (bus.fetch !== 1'b1 || bus.cycle !== 3'd0) begin
            bad++; $display("FAIL b2b_refetch got=%b/%0d exp=1/0", bus.fetch, bus.cycle); end
        bus.rcyc = 1'b0; step();
        total++; if (bus.inst !== 8'h00 || bus.cycle !== 3'd0 || bus.fetch !== 1'b0) begin
            bad++; $display("FAIL b2b_clrinj got=%h/%0d/%b exp=00/0/0", bus.inst, bus.cycle, bus.fetch); end
        bus.sinst = 1'b1; step();
        bus.sinst = 1'b0;
        total++; if (bus.clrpend !== 1'b0) begin bad++; $display("FAIL b2b_clrack got=%b exp=0", bus.clrpend); end
        bus.rcyc = 1'b1; step();
        bus.rcyc = 1'b0; step();
        total++; if (bus.inst !== 8'hA9 || bus.cycle !== 3'd1) begin
            bad++; $display("FAIL b2b_opcode got=%h/%0d exp=a9/1", bus.inst, bus.cycle); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        clr = 1'b1;
        bus.databus = 8'h00;
        bus.icyc = 1'b0;
        bus.rcyc = 1'b0;
        bus.scyc = 1'b0;
        bus.sinst = 1'b0;
        bus.nmi = 1'b0;
        bus.irq = 1'b0;
        bus.irqdis = 1'b0;

        test_reset();
        test_fetch();
        test_irq_mask();
        test_priority();
        test_stall_overflow();
        test_abort();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
